simd_mem_stream_reader: RTL

//   Read-side initiator for the single-port SIMD scratch RAMs.
//   - Given a start command (base, stride, count), it drives read_req/read_addr

---
 rtl/simd_mem_stream_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/simd_mem_stream_reader.sv
// simd_mem_stream_reader
//   Read-side initiator for a single-port SIMD scratch RAM that has registered
//   read data (one-cycle latency). A start command (base, stride, count) makes
//   the block issue count reads at base, base+stride, ... (addresses wrap), and
//   return the words in order on a valid/ready stream. A small return FIFO
//   absorbs the RAM latency and downstream backpressure.
//
// Ports
//   clk_i          clock, posedge
//   reset_i        synchronous active-high reset
//   start_i        command strobe, accepted only while idle
//   base_addr_i    first read address (sampled with start_i)
//   stride_i       address increment (sampled with start_i)
//   count_i        number of words to read (sampled with start_i)
//   busy_o         command in progress
//   done_o         one-cycle completion pulse
//   read_req_o     RAM read strobe
//   read_addr_o    RAM read address
//   read_data_i    RAM read data, valid the cycle after read_req_o
//   m_valid_o      stream word available
//   m_ready_i      downstream accepts the word
//   m_data_o       stream word
//   m_last_o       current stream word is the final word of the command
module simd_mem_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  read_req_o,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [CNT_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  pending_q;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]       occ_q, occ_d;

  logic [OccW-1:0] in_flight;
  logic            issue;
  logic            push;
  logic            pop;
  logic            fifo_empty;

  // Credit check: a slot is reserved for the read already in flight, so the
  // FIFO can never overflow. Uses registered state only, never m_ready_i.
  assign in_flight  = occ_q + OccW'(pending_q);
  assign issue      = (state_q == StRun) && (issue_left_q != '0) && (in_flight < DepthOcc);
  assign fifo_empty = (occ_q == '0);
  assign push       = pending_q;
  assign pop        = ~fifo_empty & m_ready_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = StRun;
            addr_d       = base_addr_i;
            stride_d     = stride_i;
            issue_left_d = count_i;
            out_left_d   = count_i;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d       = addr_q + stride_q;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == CNT_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
      end
      default: state_d = StIdle;
    endcase

    // The final word always leaves after the last read was issued, so this
    // only ever fires in StDrain.
    if (pop) begin
      out_left_d = out_left_q - 1'b1;
      if (out_left_q == CNT_WIDTH'(1)) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  assign occ_d = occ_q + OccW'(push) - OccW'(pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      stride_q     <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      pending_q    <= issue;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_q + PtrW'(push);
      rd_ptr_q     <= rd_ptr_q + PtrW'(pop);
      occ_q        <= occ_d;
    end
  end

  // Storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      fifo_mem[wr_ptr_q] <= read_data_i;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign read_req_o  = issue;
  assign read_addr_o = addr_q;
  assign m_valid_o   = ~fifo_empty;
  assign m_data_o    = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign m_last_o    = ~fifo_empty & (out_left_q == CNT_WIDTH'(1));

endmodule
